// File: rtl/ram_writer_pkg.sv
// Shared types and constants for the RAM block writer: FSM state enum,
// default parameter values and beat-count helpers.
package ram_writer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  localparam int DEF_DATA_W    = 128;
  localparam int DEF_BYTE_W    = 8;
  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_BASE_ADDR = 1;

  // Number of RAM words needed to store one block.
  function automatic int beat_count(input int data_w, input int byte_w);
    return data_w / byte_w;
  endfunction

  // Beat counter width; never narrower than one bit so single-beat blocks still elaborate.
  function automatic int beat_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_beat_mux.sv
// Combinational selector: returns word k of the holding register,
// least-significant word at k = 0.
module ram_beat_mux
  import ram_writer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int BYTE_W = DEF_BYTE_W,
  parameter int N      = beat_count(DATA_W, BYTE_W),
  parameter int SEL_W  = beat_cnt_w(N)
) (
  input  logic [DATA_W-1:0] hold,
  input  logic [SEL_W-1:0]  sel,
  output logic [BYTE_W-1:0] beat_data
);

  always_comb begin
    beat_data = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SEL_W'(i)) beat_data = hold[i*BYTE_W +: BYTE_W];
    end
  end

endmodule

// File: rtl/ram_block_writer.sv
// Serialises a DATA_W block into N consecutive BYTE_W RAM writes.
// Optional feature macro RAM_BLOCK_WRITER_APPEND_EN: blocks continue at the address after the previous block.
module ram_block_writer
  import ram_writer_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BYTE_W    = DEF_BYTE_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              abort,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [BYTE_W-1:0] ram_wdata,
  output logic              busy,
  output logic              done
);

  localparam int N  = beat_count(DATA_W, BYTE_W);
  localparam int CW = beat_cnt_w(N);
  localparam logic [CW-1:0]     LAST_BEAT = CW'(N - 1);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

  if (((DATA_W % BYTE_W) != 0) || (DATA_W < BYTE_W)) begin : g_bad_width
    $error("ram_block_writer: DATA_W must be a non-zero integer multiple of BYTE_W");
  end

  state_t              state, state_nxt;
  logic [CW-1:0]       beat;
  logic [DATA_W-1:0]   hold;
  logic                last_beat;
  logic                accept;
  logic [ADDR_W-1:0]   start_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // abort outranks both acceptance and completion on the final beat
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    ram_we    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    last_beat = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !abort;
        accept   = in_valid && !abort;
        if (accept) state_nxt = WRITE;
      end
      WRITE: begin
        ram_we    = 1'b1;
        busy      = 1'b1;
        last_beat = (beat == LAST_BEAT);
        in_ready  = last_beat && !abort;
        accept    = in_valid && last_beat && !abort;
        done      = last_beat && !abort;
        if (abort)                       state_nxt = IDLE;
        else if (last_beat && !accept)   state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef RAM_BLOCK_WRITER_APPEND_EN
  logic [ADDR_W-1:0] next_base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_base <= BASE;
    end else if (state == WRITE) begin
      if (abort)          next_base <= BASE;
      else if (last_beat) next_base <= ram_addr + ADDR_W'(1);
    end
  end

  // A block chained on the final beat cannot wait for next_base to update.
  assign start_addr = last_beat ? (ram_addr + ADDR_W'(1)) : next_base;
`else
  assign start_addr = BASE;
`endif

  // Beat counter and address hold their values in IDLE so ram_addr/ram_wdata stay put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold     <= '0;
      beat     <= '0;
      ram_addr <= BASE;
    end else if (accept) begin
      hold     <= in_data;
      beat     <= '0;
      ram_addr <= start_addr;
    end else if ((state == WRITE) && !abort && !last_beat) begin
      beat     <= beat + CW'(1);
      ram_addr <= ram_addr + ADDR_W'(1);
    end
  end

  ram_beat_mux #(
    .DATA_W (DATA_W),
    .BYTE_W (BYTE_W),
    .N      (N),
    .SEL_W  (CW)
  ) u_beat_mux (
    .hold      (hold),
    .sel       (beat),
    .beat_data (ram_wdata)
  );

endmodule
